// File: rtl/rx_synth.sv
// Serial frame receiver: start, 8 data slots LSB first, parity slot, 1-2 stop bits.
// Checks parity and stop bits and presents the byte with a one-cycle valid strobe.
module rx_synth #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic [1:0] par,
   input  logic       dnum,
   input  logic       snum,
   output logic [7:0] dout,
   output logic       valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] C_HALF = CW'(HALF);
   localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
   } state_t;

   state_t        r_state, w_next;
   logic          r_rs1, r_rs;
   logic          r_armed, r_busy, r_valid, r_perr, r_ferr, r_stop_bad;
   logic          r_pbit, r_dnum, r_snum;
   logic [1:0]    r_par;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift, r_dout;
   logic          w_detect, w_confirm, w_bit_end, w_sample;
   logic [7:0]    w_data;

   function automatic logic f_parity_err(input logic [7:0] d, input logic p,
                                          input logic [1:0] mode);
      case (mode)
         2'b00:   f_parity_err = (^d) != p;
         2'b11:   f_parity_err = (~^d) != p;
         default: f_parity_err = 1'b0;
      endcase
   endfunction

   // DONE also watches for a start bit so back-to-back frames work at 1 clk/bit
   always_comb begin
      w_detect  = r_armed && !r_rs &&
                  (r_state == S_IDLE || (r_state == S_DONE && !r_stop_bad));
      w_bit_end = (r_cnt == C_LAST);
      w_next    = r_state;
      w_confirm = 1'b0;
      w_sample  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_next = S_IDLE;
            if (w_detect) begin
               if (HALF == 0) begin
                  w_next    = S_DATA;
                  w_confirm = 1'b1;
               end else begin
                  w_next = S_START;
               end
            end
         end
         S_START: begin
            if (r_cnt == C_HALF) begin
               if (!r_rs) begin
                  w_next    = S_DATA;
                  w_confirm = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_sample = 1'b1;
               if (r_idx == 3'd7) w_next = S_PARITY;
            end
         end
         S_PARITY: if (w_bit_end) w_next = S_STOP1;
         S_STOP1:  if (w_bit_end) w_next = r_snum ? S_DONE : S_STOP2;
         S_STOP2:  if (w_bit_end) w_next = S_DONE;
         default:  w_next = S_IDLE;
      endcase
      w_data = r_dnum ? {1'b0, r_shift[6:0]} : r_shift;
   end

   // The detect edge itself counts as tick 0 of the start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_rs1      <= 1'b1;
         r_rs       <= 1'b1;
         r_armed    <= 1'b0;
         r_cnt      <= '0;
         r_idx      <= '0;
         r_stop_bad <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
         r_dout     <= '0;
      end else begin
         r_rs1   <= rx;
         r_rs    <= r_rs1;
         r_state <= w_next;

         if (w_detect)
            r_cnt <= (HALF == 0) ? '0 : C_ONE;
         else if (w_confirm || r_state == S_IDLE || r_state == S_DONE)
            r_cnt <= '0;
         else if (r_state != S_START && w_bit_end)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + C_ONE;

         if (w_confirm)     r_idx <= '0;
         else if (w_sample) r_idx <= r_idx + 3'd1;

         if (w_detect)
            r_stop_bad <= 1'b0;
         else if ((r_state == S_STOP1 || r_state == S_STOP2) && w_bit_end && !r_rs)
            r_stop_bad <= 1'b1;

         // A framing error disarms until the line is seen idle again
         if (r_state == S_DONE)                r_armed <= !r_stop_bad;
         else if (r_state == S_IDLE && r_rs)   r_armed <= 1'b1;

         if (w_confirm)                r_busy <= 1'b1;
         else if (r_state == S_DONE)   r_busy <= 1'b0;

         r_valid <= (r_state == S_DONE);
         if (r_state == S_DONE) begin
            r_dout <= w_data;
            r_perr <= f_parity_err(w_data, r_pbit, r_par);
            r_ferr <= r_stop_bad;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_sample) r_shift[r_idx] <= r_rs;
      if (r_state == S_PARITY && w_bit_end) r_pbit <= r_rs;
      if (w_detect) begin
         r_par  <= par;
         r_dnum <= dnum;
         r_snum <= snum;
      end
   end

   assign dout       = r_dout;
   assign valid      = r_valid;
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;
   assign busy       = r_busy;

endmodule
